bsh_arb: RTL and testbench
==========================

# bsh_arb

Round-robin arbiter and pipeline controller that shares one `bsh_32` 32-bit rotator between two requesters. Each requester issues a rotate operation (data, direction, amount) over a valid/ready handshake. The block grants one request per cycle, runs it through a two-stage operand/result pipeline around the internal `bsh_32` instance, and returns the rotated word tagged with the requester ID on a single valid/ready response port. It sits between the two client units and the shared shifter datapath.

## Interface
- `CNT_W`, default 16: width of the per-requester grant counters (only with `BSH_ARB_STATS_EN`).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  bit i: requester i has an operation pending.
- `req_ready`  out  2  bit i: requester i's operation is accepted this cycle.
- `req_data0`, `req_data1`  in  32  operand word per requester.
- `req_dir`  in  2  bit i: 0 = rotate left, 1 = rotate right.
- `req_sh0`, `req_sh1`  in  5  rotate amount, 0..31.
- `out_valid`  out  1  result register holds a valid result.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  32  rotated word.
- `out_id`  out  1  index of the requester that issued the result.
- `grant_cnt0`, `grant_cnt1`  out  `CNT_W`  grant counters, present only with `BSH_ARB_STATS_EN`.

## Operation
- Rotate semantics: left gives `({d,d} << sh)[63:32]`. Right gives `({d,d} >> sh)[31:0]`. `sh` = 0 passes the word through unchanged.
- Stage S1 is the operand register: `s1_valid`, data, dir, sh, id.
- Stage S2 is the result register: `out_valid`, `out_data`, `out_id`. It captures the `bsh_32` output computed from the S1 operands.
- `s2_adv = s1_valid & (~out_valid | out_ready)`.
- `s1_free = ~s1_valid | s2_adv`.
- Arbitration is combinational from `req_valid` and the priority pointer `ptr`:
  - If only one requester is valid, it wins.
  - If both are valid, requester `ptr` wins.
  - `req_ready[i] = s1_free & win[i]`. At most one bit of `req_ready` is set.
- Handshake: a transfer occurs when `req_valid[i] & req_ready[i]`. A requester must hold its valid, data, dir and sh stable until it is accepted. A requester that is not granted sees `req_ready[i]` = 0.
- On an accepted transfer from requester i, `ptr` becomes `~i`. `ptr` does not change when nothing is accepted.
- Simultaneous events:
  - S1 load and S2 advance in the same cycle is legal. S1 takes the new operation while S2 takes the old one.
  - Result accept (`out_valid & out_ready`) with no `s2_adv` clears `out_valid`.
- Backpressure: while `out_valid & ~out_ready`, S2 holds. S1 then holds once it is full, and `req_ready` = 0.
- Results leave in acceptance order. No operation is dropped or duplicated.

## Timing
- Reset values: `req_ready` = 0, `out_valid` = 0, `out_data` = 0, `out_id` = 0, `s1_valid` = 0, `ptr` = 0, counters = 0.
- Reset applied mid-operation discards S1 and S2 contents immediately (asynchronously).
- While `rst_n` is low and on the first cycle after release, `req_ready` = 0. `req_ready` is gated by a registered `rst_done` flag.
- Latency: an operation accepted at edge N has `out_valid` = 1 after edge N+1, provided S2 was free or drained at N+1.
- Throughput: one operation per cycle when `out_ready` is held high.
- No combinational path from `out_ready` to `out_valid` or `out_data`. The path `out_ready` → `req_ready` is combinational and permitted.

## Configuration
- `BSH_ARB_STATS_EN` defined:
  - `grant_cnt0` and `grant_cnt1` exist.
  - Each increments by 1 on every accepted transfer from its requester.
  - Each saturates at 2^`CNT_W`-1 and resets to 0.
- `BSH_ARB_STATS_EN` undefined:
  - Counter ports and logic are absent.
  - All other behaviour is identical.

## Test plan
- Single requester: requester 0 sends d=0x80000001, left, sh=1, with `out_ready`=1. Expect `out_data`=0x00000003 and `out_id`=0 one edge after acceptance. Then d=0x00000001, right, sh=4 gives 0x10000000.
- Contention: both requesters valid for 4 cycles from reset, `out_ready`=1. Grant order is 0,1,0,1. Results arrive in that order with matching `out_id`. No cycle has both `req_ready` bits set.
- Backpressure: `out_ready`=0 for 5 cycles with requester 1 streaming.
  - Exactly 2 operations are accepted (S1 and S2 fill). `req_ready`=0 afterwards.
  - `out_data` stays stable.
  - Releasing `out_ready` drains both results in order.
- Boundary amounts: sh=0 and sh=31 in both directions on 0xDEADBEEF.
  - sh=0 returns 0xDEADBEEF.
  - Left 31 returns 0xEF56DF77.
  - Right 31 returns 0xBD5B7DDF.
- Reset mid-flight: assert `rst_n`=0 while S1 and S2 are full. Expect `out_valid`=0 immediately and no stale result after release. `ptr` returns to 0.
- With `BSH_ARB_STATS_EN`, `CNT_W`=4: stream 20 requester-0 operations. Expect `grant_cnt0`=15 (saturated) and `grant_cnt1`=0.

Source files
------------

// File: rtl/bsh_arb.sv
// bsh_arb: round-robin arbiter and two-stage pipeline sharing one 32-bit
// rotator (bsh_32) between two requesters.
//
// Optional feature macro: BSH_ARB_STATS_EN adds per-requester saturating
// grant counters (parameter CNT_W, ports grant_cnt0/grant_cnt1).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid[1:0]          per-requester operation pending
//   req_ready[1:0]          per-requester accept (combinational, one-hot or 0)
//   req_data0/1[31:0]       operand word per requester
//   req_dir[1:0]            0 = rotate left, 1 = rotate right
//   req_sh0/1[4:0]          rotate amount
//   out_valid/out_ready     result handshake
//   out_data[31:0]          rotated word
//   out_id                  requester that issued the result
//   grant_cnt0/1[CNT_W-1:0] grant counters (BSH_ARB_STATS_EN only)

// Combinational 32-bit rotator.
module bsh_32 (
    input  logic [31:0] d,
    input  logic        dir,
    input  logic [4:0]  sh,
    output logic [31:0] y
);
    logic [63:0] dd;

    always_comb begin
        dd = {d, d};
        if (dir) begin
            y = 32'(dd >> sh);
        end else begin
            y = 32'((dd << sh) >> 32);
        end
    end
endmodule

module bsh_arb
`ifdef BSH_ARB_STATS_EN
#(
    parameter int unsigned CNT_W = 16
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_data0,
    input  logic [31:0] req_data1,
    input  logic [1:0]  req_dir,
    input  logic [4:0]  req_sh0,
    input  logic [4:0]  req_sh1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_id
`ifdef BSH_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 5;

    logic          rst_done;
    logic          ptr;

    logic          s1_valid;
    logic [DW-1:0] s1_data;
    logic          s1_dir;
    logic [SW-1:0] s1_sh;
    logic          s1_id;

    logic          s2_adv;
    logic          s1_free;
    logic [1:0]    win;
    logic          acc;
    logic          acc_id;
    logic [DW-1:0] sel_data;
    logic          sel_dir;
    logic [SW-1:0] sel_sh;
    logic [DW-1:0] rot_y;

    // Pipeline flow control, arbitration and operand select.
    always_comb begin
        s2_adv   = s1_valid & (~out_valid | out_ready);
        s1_free  = ~s1_valid | s2_adv;
        // Lone requester wins; on contention the pointer decides.
        win[0]   = req_valid[0] & (~req_valid[1] | ~ptr);
        win[1]   = req_valid[1] & (~req_valid[0] | ptr);
        req_ready = (rst_done & s1_free) ? win : 2'b00;
        acc      = |(req_valid & req_ready);
        acc_id   = req_ready[1];
        sel_data = acc_id ? req_data1 : req_data0;
        sel_dir  = acc_id ? req_dir[1] : req_dir[0];
        sel_sh   = acc_id ? req_sh1 : req_sh0;
    end

    bsh_32 u_bsh (
        .d   (s1_data),
        .dir (s1_dir),
        .sh  (s1_sh),
        .y   (rot_y)
    );

    // Gates req_ready off for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // Round-robin pointer: after a grant the other requester gets priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (acc) begin
            ptr <= ~acc_id;
        end
    end

    // S1 operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_dir   <= 1'b0;
            s1_sh    <= '0;
            s1_id    <= 1'b0;
        end else if (s1_free) begin
            s1_valid <= acc;
            if (acc) begin
                s1_data <= sel_data;
                s1_dir  <= sel_dir;
                s1_sh   <= sel_sh;
                s1_id   <= acc_id;
            end
        end
    end

    // S2 result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= 1'b1;
            out_data  <= rot_y;
            out_id    <= s1_id;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef BSH_ARB_STATS_EN
    // Saturating per-requester grant counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (acc) begin
            if (!acc_id && (grant_cnt0 != {CNT_W{1'b1}})) begin
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
            if (acc_id && (grant_cnt1 != {CNT_W{1'b1}})) begin
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_bsh_arb.sv
// Self-checking bench for bsh_arb: per-cycle model comparison plus
// hand-computed result sequences for each directed scenario.
module tb_bsh_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_data0, req_data1;
    logic [1:0]  req_dir;
    logic [4:0]  req_sh0, req_sh1;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_id;
`ifdef BSH_ARB_STATS_EN
    logic [3:0]  grant_cnt0, grant_cnt1;
`endif

    typedef struct {
        logic [31:0] d;
        logic        dir;
        logic [4:0]  sh;
    } op_t;

    op_t q0[$];
    op_t q1[$];
    logic        v0 = 1'b0, v1 = 1'b0, dir0 = 1'b0, dir1 = 1'b0;
    logic [31:0] d0 = '0, d1 = '0;
    logic [4:0]  sh0 = '0, sh1 = '0;
    bit          acc0, acc1;
    int          acc_total;
    logic [31:0] got_d[$];
    bit          got_id[$];
    int          n_chk;
    int          n_fail;

    // Model state
    bit          m_rd, m_ptr, m_s1v, m_s1id, m_ov, m_oid;
    logic [31:0] m_s1res, m_od;

    assign req_valid = {v1, v0};
    assign req_dir   = {dir1, dir0};
    assign req_data0 = d0;
    assign req_data1 = d1;
    assign req_sh0   = sh0;
    assign req_sh1   = sh1;

    always #5 clk = ~clk;

`ifdef BSH_ARB_STATS_EN
    bsh_arb #(.CNT_W(4)) dut (
`else
    bsh_arb dut (
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_dir   (req_dir),
        .req_sh0   (req_sh0),
        .req_sh1   (req_sh1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
`ifdef BSH_ARB_STATS_EN
        ,
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1)
`endif
    );

    // Rotation by repeated single-bit steps.
    function automatic logic [31:0] rot(input logic [31:0] d, input logic dir, input logic [4:0] sh);
        logic [31:0] r;
        r = d;
        for (int k = 0; k < int'(sh); k++) begin
            if (dir) r = {r[0], r[31:1]};
            else     r = {r[30:0], r[31]};
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [31:0] d, input logic dir, input logic [4:0] sh);
        op_t o;
        o.d = d; o.dir = dir; o.sh = sh;
        q0.push_back(o);
    endtask

    task automatic push1(input logic [31:0] d, input logic dir, input logic [4:0] sh);
        op_t o;
        o.d = d; o.dir = dir; o.sh = sh;
        q1.push_back(o);
    endtask

    task automatic clr_got();
        got_d.delete();
        got_id.delete();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_s1v || m_ov) && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (n >= 300) begin
            n_fail++;
            $display("FAIL drain_timeout: pipeline not idle after %0d cycles", n);
        end
        @(negedge clk);
    endtask

    // Requester 0 driver: holds the head op until it is accepted.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (acc0 && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                v0 = 1'b1; d0 = q0[0].d; dir0 = q0[0].dir; sh0 = q0[0].sh;
            end else begin
                v0 = 1'b0;
            end
        end
    end

    // Requester 1 driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (acc1 && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                v1 = 1'b1; d1 = q1[0].d; dir1 = q1[0].dir; sh1 = q1[0].sh;
            end else begin
                v1 = 1'b0;
            end
        end
    end

    // Model and per-cycle compare.
    initial begin
        bit          s2a, s1f, w0, w1;
        logic [1:0]  er;
        bit          n_rd, n_ptr, n_s1v, n_s1id, n_ov, n_oid;
        logic [31:0] n_s1res, n_od;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_req_ready", 32'(req_ready), 32'd0);
                chk("reset_out_valid", 32'(out_valid), 32'd0);
                acc0 = 1'b0;
                acc1 = 1'b0;
            end else begin
                s2a = m_s1v && (!m_ov || out_ready);
                s1f = !m_s1v || s2a;
                w0  = req_valid[0] && (!req_valid[1] || !m_ptr);
                w1  = req_valid[1] && (!req_valid[0] || m_ptr);
                er  = (m_rd && s1f) ? {w1, w0} : 2'b00;
                chk("req_ready", 32'(req_ready), 32'(er));
                chk("ready_onehot", 32'(req_ready == 2'b11), 32'd0);
                chk("out_valid", 32'(out_valid), 32'(m_ov));
                if (m_ov) begin
                    chk("out_data", out_data, m_od);
                    chk("out_id", 32'(out_id), 32'(m_oid));
                end
                acc0 = req_valid[0] & req_ready[0];
                acc1 = req_valid[1] & req_ready[1];
                if (acc0 || acc1) acc_total++;
                if (out_valid && out_ready) begin
                    got_d.push_back(out_data);
                    got_id.push_back(out_id);
                end
                n_rd = 1'b1; n_ptr = m_ptr; n_s1v = m_s1v; n_s1id = m_s1id; n_s1res = m_s1res;
                n_ov = m_ov; n_oid = m_oid; n_od = m_od;
                if (s2a) begin
                    n_ov = 1'b1; n_od = m_s1res; n_oid = m_s1id;
                end else if (m_ov && out_ready) begin
                    n_ov = 1'b0;
                end
                if (er[0] && req_valid[0]) begin
                    n_s1v = 1'b1; n_s1id = 1'b0; n_ptr = 1'b1;
                    n_s1res = rot(req_data0, req_dir[0], req_sh0);
                end else if (er[1] && req_valid[1]) begin
                    n_s1v = 1'b1; n_s1id = 1'b1; n_ptr = 1'b0;
                    n_s1res = rot(req_data1, req_dir[1], req_sh1);
                end else if (s2a) begin
                    n_s1v = 1'b0;
                end
            end
            @(posedge clk);
            if (!rst_n) begin
                m_rd = 0; m_ptr = 0; m_s1v = 0; m_s1id = 0; m_ov = 0; m_oid = 0;
                m_s1res = '0; m_od = '0;
            end else begin
                m_rd = n_rd; m_ptr = n_ptr; m_s1v = n_s1v; m_s1id = n_s1id; m_s1res = n_s1res;
                m_ov = n_ov; m_oid = n_oid; m_od = n_od;
            end
        end
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Directed scenarios.
    initial begin
        int a;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid_lit", 32'(out_valid), 32'd0);
        chk("rst_out_data_lit", out_data, 32'd0);
        chk("rst_out_id_lit", 32'(out_id), 32'd0);
        chk("rst_req_ready_lit", 32'(req_ready), 32'd0);
`ifdef BSH_ARB_STATS_EN
        chk("rst_cnt0", 32'(grant_cnt0), 32'd0);
        chk("rst_cnt1", 32'(grant_cnt1), 32'd0);
`endif
        rst_n = 1'b1;
        step();

        // Single requester
        clr_got();
        push0(32'h8000_0001, 1'b0, 5'd1);
        wait_idle();
        step();
        push0(32'h0000_0001, 1'b1, 5'd4);
        wait_idle();
        chk("single_count", 32'(got_d.size()), 32'd2);
        if (got_d.size() == 2) begin
            chk("single_d0", got_d[0], 32'h0000_0003);
            chk("single_id0", 32'(got_id[0]), 32'd0);
            chk("single_d1", got_d[1], 32'h1000_0000);
        end
        step();

        // Boundary amounts
        clr_got();
        push0(32'hDEAD_BEEF, 1'b0, 5'd0);
        push0(32'hDEAD_BEEF, 1'b1, 5'd0);
        push0(32'hDEAD_BEEF, 1'b0, 5'd31);
        push0(32'hDEAD_BEEF, 1'b1, 5'd31);
        wait_idle();
        chk("bound_count", 32'(got_d.size()), 32'd4);
        if (got_d.size() == 4) begin
            chk("bound_l0", got_d[0], 32'hDEAD_BEEF);
            chk("bound_r0", got_d[1], 32'hDEAD_BEEF);
            chk("bound_l31", got_d[2], 32'hEF56_DF77);
            chk("bound_r31", got_d[3], 32'hBD5B_7DDF);
        end
        step();

        // Contention from reset
        rst_n = 1'b0;
        clr_got();
        push0(32'h11, 1'b0, 5'd4);
        push0(32'h33, 1'b0, 5'd4);
        push1(32'h22, 1'b0, 5'd4);
        push1(32'h44, 1'b0, 5'd4);
        step();
        step();
        rst_n = 1'b1;
        wait_idle();
        chk("cont_count", 32'(got_d.size()), 32'd4);
        if (got_d.size() == 4) begin
            chk("cont_id0", 32'(got_id[0]), 32'd0);
            chk("cont_id1", 32'(got_id[1]), 32'd1);
            chk("cont_id2", 32'(got_id[2]), 32'd0);
            chk("cont_id3", 32'(got_id[3]), 32'd1);
            chk("cont_d0", got_d[0], 32'h110);
            chk("cont_d1", got_d[1], 32'h220);
            chk("cont_d2", got_d[2], 32'h330);
            chk("cont_d3", got_d[3], 32'h440);
        end
        step();

        // Backpressure
        clr_got();
        out_ready = 1'b0;
        a = acc_total;
        push1(32'h1, 1'b0, 5'd8);
        push1(32'h2, 1'b0, 5'd8);
        push1(32'h3, 1'b0, 5'd8);
        push1(32'h4, 1'b1, 5'd4);
        push1(32'h5, 1'b1, 5'd0);
        repeat (5) step();
        @(negedge clk);
        chk("bp_accepted", 32'(acc_total - a), 32'd2);
        chk("bp_ready", 32'(req_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_out_data", out_data, 32'h100);
        step();
        out_ready = 1'b1;
        wait_idle();
        chk("bp_count", 32'(got_d.size()), 32'd5);
        if (got_d.size() == 5) begin
            chk("bp_d0", got_d[0], 32'h100);
            chk("bp_d1", got_d[1], 32'h200);
            chk("bp_d2", got_d[2], 32'h300);
            chk("bp_d3", got_d[3], 32'h4000_0000);
            chk("bp_d4", got_d[4], 32'h5);
            chk("bp_id4", 32'(got_id[4]), 32'd1);
        end
        step();

        // Reset mid-flight
        out_ready = 1'b0;
        push0(32'hA, 1'b0, 5'd1);
        push0(32'hB, 1'b0, 5'd1);
        push0(32'hC, 1'b0, 5'd1);
        repeat (4) step();
        #1;
        chk("mf_full_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mf_async_valid", 32'(out_valid), 32'd0);
        chk("mf_async_ready", 32'(req_ready), 32'd0);
        q0.delete();
        q1.delete();
        step();
        clr_got();
        out_ready = 1'b1;
        push0(32'h1, 1'b0, 5'd1);
        push1(32'h1, 1'b0, 5'd2);
        step();
        rst_n = 1'b1;
        wait_idle();
        chk("mf_count", 32'(got_d.size()), 32'd2);
        if (got_d.size() == 2) begin
            chk("mf_id0", 32'(got_id[0]), 32'd0);
            chk("mf_d0", got_d[0], 32'h2);
            chk("mf_id1", 32'(got_id[1]), 32'd1);
            chk("mf_d1", got_d[1], 32'h4);
        end
        step();

`ifdef BSH_ARB_STATS_EN
        // Counter saturation
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) push0(32'(i), 1'b0, 5'd3);
        wait_idle();
        chk("stats_cnt0", 32'(grant_cnt0), 32'd15);
        chk("stats_cnt1", 32'(grant_cnt1), 32'd0);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
